// File: rtl/kp_scan_ctrl.sv
// 4x4 keypad scan controller: sequenced row strobes, press/release debounce,
// keycode encoding and a small valid/ready event FIFO.
module kp_scan_ctrl #(
  parameter int DWELL      = 1000,
  parameter int DB_CYCLES  = 65536,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       multi_err,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int DW_W  = $clog2(DWELL);
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DW_W-1:0]  DW_ZERO   = DW_W'(0);
  localparam logic [DW_W-1:0]  DW_ONE    = DW_W'(1);
  localparam logic [DW_W-1:0]  DW_LAST   = DW_W'(DWELL - 1);
  localparam logic [DB_W-1:0]  DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_PRESS_DB = 3'd2,
    ST_HELD     = 3'd3,
    ST_REL_DB   = 3'd4
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0:    key_map = 4'h1;
      4'h1:    key_map = 4'h2;
      4'h2:    key_map = 4'h3;
      4'h3:    key_map = 4'hA;
      4'h4:    key_map = 4'h4;
      4'h5:    key_map = 4'h5;
      4'h6:    key_map = 4'h6;
      4'h7:    key_map = 4'hB;
      4'h8:    key_map = 4'h7;
      4'h9:    key_map = 4'h8;
      4'hA:    key_map = 4'h9;
      4'hB:    key_map = 4'hC;
      4'hC:    key_map = 4'hE;
      4'hD:    key_map = 4'h0;
      4'hE:    key_map = 4'hF;
      4'hF:    key_map = 4'hD;
      default: key_map = 4'h0;
    endcase
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~c[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0]) begin
      low_col = 2'd0;
    end else if (!c[1]) begin
      low_col = 2'd1;
    end else if (!c[2]) begin
      low_col = 2'd2;
    end else begin
      low_col = 2'd3;
    end
  endfunction

  state_t           state_r, state_nx;
  logic [1:0]       row_idx_r, row_idx_nx;
  logic [DW_W-1:0]  dwell_r, dwell_nx;
  logic [DB_W-1:0]  db_r, db_nx;
  logic [3:0]       col_cap_r, col_cap_nx;
  logic [3:0]       row_n_r, row_n_nx;
  logic             key_down_r, key_down_nx;
  logic             multi_err_r;
  logic             push_s, multi_s;
  logic [3:0]       push_code_s;

  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_nx, wr_ptr_r, wr_ptr_nx;
  logic [PTR_W:0]   count_r, count_nx;
  logic             key_valid_r, key_valid_nx;
  logic [3:0]       key_code_r, key_code_nx;
  logic             ovf_r, ovf_nx;
  logic             pop_s, full_s, wr_en_s, drop_s, empty_after_pop_s;

  // Scan/debounce next-state logic; row strobes and key_down follow the next state.
  always_comb begin
    state_nx   = state_r;
    row_idx_nx = row_idx_r;
    dwell_nx   = dwell_r;
    db_nx      = db_r;
    col_cap_nx = col_cap_r;
    push_s     = 1'b0;
    multi_s    = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
      dwell_nx = DW_ZERO;
      db_nx    = DB_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx   = ST_SCAN;
          row_idx_nx = 2'd0;
          dwell_nx   = DW_ZERO;
        end
        ST_SCAN: begin
          if (dwell_r == DW_LAST) begin
            dwell_nx = DW_ZERO;
            if (col_n == 4'hF) begin
              row_idx_nx = row_idx_r + 2'd1;
            end else begin
              col_cap_nx = col_n;
              db_nx      = DB_ZERO;
              state_nx   = ST_PRESS_DB;
            end
          end else begin
            dwell_nx = dwell_r + DW_ONE;
          end
        end
        ST_PRESS_DB: begin
          if (col_n != col_cap_r) begin
            state_nx   = ST_SCAN;
            row_idx_nx = row_idx_r + 2'd1;
            dwell_nx   = DW_ZERO;
          end else if (db_r == DB_LAST) begin
            state_nx = ST_HELD;
            if (low_count(col_cap_r) == 3'd1) begin
              push_s = 1'b1;
            end else begin
              multi_s = 1'b1;
            end
          end else begin
            db_nx = db_r + DB_ONE;
          end
        end
        ST_HELD: begin
          if (col_n == 4'hF) begin
            state_nx = ST_REL_DB;
            db_nx    = DB_ZERO;
          end else begin
            state_nx = ST_HELD;
          end
        end
        ST_REL_DB: begin
          if (col_n != 4'hF) begin
            db_nx = DB_ZERO;
          end else if (db_r == DB_LAST) begin
            state_nx   = ST_SCAN;
            row_idx_nx = row_idx_r + 2'd1;
            dwell_nx   = DW_ZERO;
          end else begin
            db_nx = db_r + DB_ONE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
    if (state_nx == ST_IDLE) begin
      row_n_nx = 4'hF;
    end else begin
      row_n_nx = ~(4'b0001 << row_idx_nx);
    end
    key_down_nx = (state_nx == ST_HELD) || (state_nx == ST_REL_DB);
    push_code_s = key_map(row_idx_r, low_col(col_cap_r));
  end

  // Event FIFO control; the head is registered so key_valid/key_code come from flops.
  always_comb begin
    pop_s             = key_valid_r & key_ready;
    full_s            = (count_r == CNT_FULL);
    wr_en_s           = push_s & (~full_s | pop_s);
    drop_s            = push_s & full_s & ~pop_s;
    empty_after_pop_s = (count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s);
    rd_ptr_nx         = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_ptr_nx         = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    if (wr_en_s && !pop_s) begin
      count_nx = count_r + CNT_ONE;
    end else if (!wr_en_s && pop_s) begin
      count_nx = count_r - CNT_ONE;
    end else begin
      count_nx = count_r;
    end
    key_valid_nx = (count_nx != CNT_ZERO);
    if (count_nx == CNT_ZERO) begin
      key_code_nx = 4'h0;
    end else if (wr_en_s && empty_after_pop_s) begin
      key_code_nx = push_code_s;
    end else begin
      key_code_nx = mem_r[rd_ptr_nx];
    end
    if (drop_s) begin
      ovf_nx = 1'b1;
    end else if (ovf_clr) begin
      ovf_nx = 1'b0;
    end else begin
      ovf_nx = ovf_r;
    end
  end

  // State, counters, FIFO pointers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      row_idx_r   <= 2'd0;
      dwell_r     <= DW_ZERO;
      db_r        <= DB_ZERO;
      col_cap_r   <= 4'hF;
      row_n_r     <= 4'hF;
      key_down_r  <= 1'b0;
      multi_err_r <= 1'b0;
      rd_ptr_r    <= PTR_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      row_idx_r   <= row_idx_nx;
      dwell_r     <= dwell_nx;
      db_r        <= db_nx;
      col_cap_r   <= col_cap_nx;
      row_n_r     <= row_n_nx;
      key_down_r  <= key_down_nx;
      multi_err_r <= multi_s;
      rd_ptr_r    <= rd_ptr_nx;
      wr_ptr_r    <= wr_ptr_nx;
      count_r     <= count_nx;
      key_valid_r <= key_valid_nx;
      key_code_r  <= key_code_nx;
      ovf_r       <= ovf_nx;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_code_s;
    end
  end

  assign row_n     = row_n_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_down  = key_down_r;
  assign multi_err = multi_err_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Self-checking bench for kp_scan_ctrl: keypad matrix model, event scoreboard,
// vector table, directed corner sequences and randomized presses.
module tb_kp_scan_ctrl;
  localparam int DWELL = 8;
  localparam int DB    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, key_ready = 1'b1, ovf_clr = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_down, multi_err, ovf;

  logic       key_on   = 1'b0;
  logic [1:0] key_row  = 2'd0;
  logic [3:0] key_mask = 4'h0;
  logic       rnd_ready = 1'b0;
  int         checks = 0, errors = 0, mpulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct {
    logic [1:0] row;
    logic [3:0] mask;
    logic [3:0] code;
    int         multi;
  } vec_t;
  vec_t vt [6];

  // Matrix model: a pressed key pulls its columns low only while its row is strobed.
  assign col_n = (key_on && row_n[key_row] == 1'b0) ? ~key_mask : 4'hF;

  kp_scan_ctrl #(.DWELL(DWELL), .DB_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_n(col_n), .row_n(row_n),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_down(key_down), .multi_err(multi_err), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance n cycles; every accepted event is compared with the scoreboard.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (multi_err) mpulses++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) chk("unexpected_event", int'(key_code), -1);
        else chk("event_code", int'(key_code), int'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_kd(input logic v, input int budget, input string nm);
    int n = 0;
    while (key_down !== v && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, int'(key_down), int'(v));
  endtask

  task automatic wait_row_start(input logic [3:0] r);
    int n = 0;
    while (row_n === r && n < 64) begin step(1); n++; end
    while (row_n !== r && n < 64) begin step(1); n++; end
    chk("row_reached", int'(row_n), int'(r));
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] m, input int hold);
    key_row  = r;
    key_mask = m;
    key_on   = 1'b1;
    wait_kd(1'b1, 80, "press_detect");
    step(hold);
    chk("held_down", int'(key_down), 1);
    key_on = 1'b0;
    wait_kd(1'b0, 40, "release_detect");
  endtask

  initial begin
    vt[0] = '{2'd0, 4'b0001, 4'h1, 0};
    vt[1] = '{2'd1, 4'b0100, 4'h6, 0};
    vt[2] = '{2'd2, 4'b1000, 4'hC, 0};
    vt[3] = '{2'd3, 4'b0010, 4'h0, 0};
    vt[4] = '{2'd3, 4'b0100, 4'hF, 0};
    vt[5] = '{2'd0, 4'b0011, 4'h0, 1};

    // Reset values
    step(3);
    chk("rst_row_n", int'(row_n), 15);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_key_down", int'(key_down), 0);
    chk("rst_multi_err", int'(multi_err), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Idle scan: each row strobed for DWELL cycles
    rst = 1'b0;
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 5 * DWELL; i++) begin
      logic [3:0] e;
      e = ~(4'b0001 << ((i / DWELL) % 4));
      chk("scan_row_n", int'(row_n), int'(e));
      chk("scan_no_event", int'(key_valid), 0);
      step(1);
    end

    // Clean r1/c2 press: latency, release debounce, scan resumes on next row
    key_row = 2'd1; key_mask = 4'b0100; key_on = 1'b1;
    exp_q.push_back(4'h6);
    wait_kd(1'b1, 80, "clean_detect");
    chk("clean_valid", int'(key_valid), 1);
    chk("clean_code", int'(key_code), 6);
    step(200);
    key_on = 1'b0;
    step(DB);
    chk("rel_db_down", int'(key_down), 1);
    step(1);
    chk("rel_done_down", int'(key_down), 0);
    chk("resume_row", int'(row_n), 4'b1011);
    chk("clean_drained", exp_q.size(), 0);

    // Bounce on r3/c0 during press debounce: no event until stable
    key_row = 2'd3; key_mask = 4'b0001;
    wait_row_start(4'b0111);
    step(DWELL - 1);
    key_on = 1'b1;
    step(5);
    key_on = 1'b0;
    step(2);
    chk("bounce_no_down", int'(key_down), 0);
    chk("bounce_no_valid", int'(key_valid), 0);
    chk("bounce_next_row", int'(row_n), 4'b1110);
    key_on = 1'b1;
    exp_q.push_back(4'hE);
    wait_kd(1'b1, 80, "bounce_detect");
    step(20);
    key_on = 1'b0;
    wait_kd(1'b0, 40, "bounce_release");
    chk("bounce_drained", exp_q.size(), 0);

    // Vector table, including the two-column press
    for (int v = 0; v < 6; v++) begin
      int mp0;
      mp0 = mpulses;
      if (vt[v].multi == 0) exp_q.push_back(vt[v].code);
      press(vt[v].row, vt[v].mask, 100);
      chk("vec_multi_pulses", mpulses - mp0, vt[v].multi);
      chk("vec_drained", exp_q.size(), 0);
    end

    // Overflow: five presses with the consumer stalled
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] mk;
      mk = 4'(4'b0001 << (k % 4));
      if (k < 4) exp_q.push_back(kmap[k]);
      press((k < 4) ? 2'd0 : 2'd1, mk, 20);
    end
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_head_valid", int'(key_valid), 1);
    chk("ovf_head_code", int'(key_code), 1);
    key_ready = 1'b1;
    step(8);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_empty", int'(key_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);

    // Reset during press debounce discards the press and the queued event
    key_ready = 1'b0;
    exp_q.push_back(4'h7);
    press(2'd2, 4'b0001, 20);
    key_row = 2'd0; key_mask = 4'b0100;
    wait_row_start(4'b1110);
    step(DWELL - 1);
    key_on = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_row_n", int'(row_n), 15);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_down", int'(key_down), 0);
    exp_q.delete();
    rst = 1'b0;
    key_on = 1'b0;
    key_ready = 1'b1;
    step(60);
    chk("post_rst_empty", int'(key_valid), 0);

    // Enable dropped while held: row strobes park at once, no further event
    key_row = 2'd1; key_mask = 4'b0010; key_on = 1'b1;
    exp_q.push_back(4'h5);
    wait_kd(1'b1, 80, "en_detect");
    step(5);
    enable = 1'b0;
    step(1);
    chk("en_drop_row_n", int'(row_n), 15);
    chk("en_drop_down", int'(key_down), 0);
    key_on = 1'b0;
    step(5);
    enable = 1'b1;
    step(50);
    chk("en_drop_drained", exp_q.size(), 0);
    chk("en_drop_no_valid", int'(key_valid), 0);

    // Randomized single-key presses against the keymap scoreboard
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int r, c;
      logic [3:0] mk;
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      mk = 4'(4'b0001 << c);
      exp_q.push_back(kmap[r * 4 + c]);
      press(2'(r), mk, int'($urandom_range(20, 80)));
      step(int'($urandom_range(0, 15)));
    end
    rnd_ready = 1'b0;
    key_ready = 1'b1;
    step(10);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_ovf", int'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kp_scan_ctrl.md
Name: kp_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad on ARDUINO_IO.
- Drives active-low one-hot row strobes and dwells on each row.
- Debounces press and release on the held row, then encodes the key.
- Queues one event per press in a small FIFO drained by a valid/ready consumer such as the LEDR/display logic.
- Replaces free-running per-clock row rotation with a sequenced scan that holds the row while a key is down.

Parameters:
- DWELL, 1000, clk cycles spent on each row; columns are sampled on the last dwell cycle (must be >= 2).
- DB_CYCLES, 65536, consecutive stable cycles required to accept a press or a release (must be >= 2).
- FIFO_DEPTH, 4, key-event queue depth (power of two, >= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  scan enable; low parks the FSM in IDLE.
- col_n  in  4  column lines, active-low, already 2-FF synchronized; bit0 = leftmost column.
- row_n  out  4  row strobes, active-low one-hot; bit0 = top row.
- key_valid  out  1  FIFO head valid.
- key_code  out  4  FIFO head keycode.
- key_ready  in  1  consumer accepts head when key_valid & key_ready.
- key_down  out  1  high while a debounced key is held (HELD or REL_DB).
- multi_err  out  1  one-cycle pulse: debounced press had more than one column low.
- ovf  out  1  sticky flag: event dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset values: state = IDLE, row_idx = 0, all counters 0, FIFO empty, row_n = 4'hF, key_valid = 0, key_code = 0, key_down = 0, multi_err = 0, ovf = 0.
- Reset applies mid-operation too: an in-progress debounce is discarded and FIFO contents are lost.
- Keycode map, row r / col c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- IDLE:
  - row_n = 4'hF.
  - enable = 1 -> SCAN with row_idx = 0 and dwell counter = 0.
- SCAN:
  - row_n = ~(1 << row_idx); dwell counter increments.
  - At count DWELL-1, sample col_n:
    - all high -> row_idx = row_idx + 1 (3 wraps to 0), counter = 0, stay in SCAN.
    - any low -> latch pattern into col_cap, go to PRESS_DB with counter = 0 and row held.
- PRESS_DB:
  - Row held; counter increments while col_n == col_cap.
  - Any mismatch -> SCAN, advance to next row, dwell = 0, no event.
  - At count DB_CYCLES-1 with pattern still matching:
    - exactly one column low -> push keycode, go to HELD.
    - two or more low -> pulse multi_err for one cycle, no push, go to HELD.
- HELD:
  - Row held; key_down = 1.
  - col_n == 4'hF -> REL_DB with counter = 0.
- REL_DB:
  - key_down = 1; counter increments while col_n == 4'hF.
  - Any low -> reset counter, stay in REL_DB (bounce).
  - At count DB_CYCLES-1 -> SCAN with the next row.
- enable deassert: checked in every state; takes effect next cycle -> IDLE, no push. A press already pushed remains queued.
- Counters: width $clog2 of the respective parameter; no overflow because each is compared against its terminal value.
- Latency: key_valid rises the cycle after the push cycle when the FIFO was empty (registered head).
- FIFO:
  - Pop when key_valid & key_ready.
  - Push when full without a same-cycle pop -> event dropped, ovf <= 1.
  - Push when full with a same-cycle pop -> both succeed.
  - Push and pop on the same cycle otherwise -> both succeed, count unchanged.
  - Order is strictly FIFO.
- ovf: ovf_clr clears it; a simultaneous drop wins, so ovf stays 1.
- At most one event is generated per physical press, regardless of hold time.

Test Plan:
Bench parameters: DWELL = 8, DB_CYCLES = 16, FIFO_DEPTH = 4.
- Reset, enable = 1, no key -> row_n cycles 1110, 1101, 1011, 0111, 1110, each for 8 cycles; key_valid stays 0.
- Key at r1/c2 with clean press held 200 cycles -> one entry, key_code = 4'h6; key_down high until 16 cycles after release; scan resumes at row_n = 1011.
- r3/c0 press that bounces (low 5 cycles, high 2, then stable low) -> no event before stable; exactly one event 4'hE.
- r0 with col_n = 1100 held 100 cycles -> multi_err pulses once; no FIFO push; key_down = 1 until release.
- key_ready = 0 with 5 distinct presses (1, 2, 3, A, 4) -> FIFO holds 1, 2, 3, A; ovf = 1; drain yields exactly those four in order; ovf_clr -> ovf = 0.
- rst asserted during PRESS_DB, and separately enable dropped during HELD -> no event; row_n = 4'hF next cycle; FIFO empty after rst.
